// File: rtl/ac_zone_ctrl.sv
// Multi-zone heat/cool hysteresis controller with per-zone sticky timeout fault.
// Optional minimum on/off dwell timers are built when AC_ZONE_DWELL_EN is defined.
module ac_zone_ctrl #(
  parameter int N_ZONES      = 2,
  parameter int TEMP_W       = 5,
  parameter int HYST         = 2,
  parameter int MIN_ON       = 4,
  parameter int MIN_OFF      = 4,
  parameter int FAULT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_ZONES-1:0]          enable,
  input  logic [N_ZONES*TEMP_W-1:0]   temperature,
  input  logic [N_ZONES*TEMP_W-1:0]   desired_temperature,
  output logic [N_ZONES-1:0]          heating,
  output logic [N_ZONES-1:0]          cooling,
  output logic [N_ZONES-1:0]          fault,
  output logic                        any_active
);

  localparam int FCNT_W = $clog2(FAULT_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FAULT_CYCLES);
  localparam logic [TEMP_W:0]   HYST_X   = (TEMP_W + 1)'(HYST);
  localparam logic [TEMP_W:0]   T_MAX    = {1'b0, {TEMP_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, HEAT, COOL, FLT} state_t;

  state_t            state_q [N_ZONES];
  state_t            state_d [N_ZONES];
  logic [FCNT_W-1:0] fcnt_q  [N_ZONES];
  logic [FCNT_W-1:0] fcnt_d  [N_ZONES];
  logic [FCNT_W-1:0] fcnt_inc[N_ZONES];
  logic [TEMP_W:0]   t_x     [N_ZONES];
  logic [TEMP_W:0]   d_x     [N_ZONES];
  logic [TEMP_W:0]   hi_x    [N_ZONES];
  logic [TEMP_W:0]   lo_x    [N_ZONES];
  logic              on_ok   [N_ZONES];
  logic              off_ok  [N_ZONES];

  logic [N_ZONES-1:0] heating_q, cooling_q, fault_q;
  logic [N_ZONES-1:0] heating_d, cooling_d, fault_d;
  logic               any_active_q;

  // Thresholds use one extra bit so D+HYST and D-HYST saturate instead of wrapping.
  for (genvar g = 0; g < N_ZONES; g++) begin : g_thr
    assign t_x[g]  = {1'b0, temperature[g*TEMP_W +: TEMP_W]};
    assign d_x[g]  = {1'b0, desired_temperature[g*TEMP_W +: TEMP_W]};
    assign hi_x[g] = ((d_x[g] + HYST_X) > T_MAX) ? T_MAX : (d_x[g] + HYST_X);
    assign lo_x[g] = (d_x[g] >= HYST_X) ? (d_x[g] - HYST_X) : '0;
  end

`ifdef AC_ZONE_DWELL_EN
  localparam int DWELL_MAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int DWELL_W   = $clog2(DWELL_MAX + 2);
  localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(DWELL_MAX);

  logic [DWELL_W-1:0] dwell_q[N_ZONES];
  logic [DWELL_W-1:0] dwell_d[N_ZONES];

  // dwell_q counts cycles completed before the current one, so the current
  // cycle is number dwell_q+1 spent in the state.
  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      on_ok[i]  = (int'(dwell_q[i]) + 1) >= MIN_ON;
      off_ok[i] = (int'(dwell_q[i]) + 1) >= MIN_OFF;
      if (state_d[i] != state_q[i])
        dwell_d[i] = '0;
      else if (dwell_q[i] >= DWELL_SAT)
        dwell_d[i] = DWELL_SAT;
      else
        dwell_d[i] = dwell_q[i] + 1'b1;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      on_ok[i]  = 1'b1;
      off_ok[i] = 1'b1;
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      state_d[i]  = state_q[i];
      fcnt_d[i]   = fcnt_q[i];
      fcnt_inc[i] = (fcnt_q[i] >= FCNT_MAX) ? FCNT_MAX : (fcnt_q[i] + 1'b1);
      if (!enable[i]) begin
        state_d[i] = IDLE;
        fcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            fcnt_d[i] = '0;
            if (t_x[i] >= hi_x[i] && off_ok[i])
              state_d[i] = COOL;
            else if (t_x[i] <= lo_x[i] && off_ok[i])
              state_d[i] = HEAT;
          end
          HEAT: begin
            fcnt_d[i] = fcnt_inc[i];
            if (fcnt_inc[i] == FCNT_MAX)
              state_d[i] = FLT;
            else if (t_x[i] >= d_x[i] && on_ok[i]) begin
              state_d[i] = IDLE;
              fcnt_d[i]  = '0;
            end
          end
          COOL: begin
            fcnt_d[i] = fcnt_inc[i];
            if (fcnt_inc[i] == FCNT_MAX)
              state_d[i] = FLT;
            else if (t_x[i] <= d_x[i] && on_ok[i]) begin
              state_d[i] = IDLE;
              fcnt_d[i]  = '0;
            end
          end
          default: state_d[i] = FLT;
        endcase
      end
      heating_d[i] = (state_d[i] == HEAT);
      cooling_d[i] = (state_d[i] == COOL);
      fault_d[i]   = (state_d[i] == FLT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ZONES; i++) begin
        state_q[i] <= IDLE;
        fcnt_q[i]  <= '0;
`ifdef AC_ZONE_DWELL_EN
        dwell_q[i] <= DWELL_SAT;
`endif
      end
      heating_q    <= '0;
      cooling_q    <= '0;
      fault_q      <= '0;
      any_active_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        state_q[i] <= state_d[i];
        fcnt_q[i]  <= fcnt_d[i];
`ifdef AC_ZONE_DWELL_EN
        dwell_q[i] <= dwell_d[i];
`endif
      end
      heating_q    <= heating_d;
      cooling_q    <= cooling_d;
      fault_q      <= fault_d;
      any_active_q <= |{heating_d, cooling_d};
    end
  end

  assign heating    = heating_q;
  assign cooling    = cooling_q;
  assign fault      = fault_q;
  assign any_active = any_active_q;

endmodule

// File: tb/tb_ac_zone_ctrl.sv
// Directed vector bench for ac_zone_ctrl in its default (no dwell) build.
module tb_ac_zone_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] enable;
  logic [9:0] temperature;
  logic [9:0] desired_temperature;
  logic [1:0] heating, cooling, fault;
  logic       any_active;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ac_zone_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .temperature         (temperature),
    .desired_temperature (desired_temperature),
    .heating             (heating),
    .cooling             (cooling),
    .fault               (fault),
    .any_active          (any_active)
  );

  typedef struct {
    logic       r;
    logic [1:0] en;
    logic [4:0] t0, d0, t1, d1;
    logic [1:0] heat, cool, flt;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input logic r, input logic [1:0] en,
                      input logic [4:0] t0, input logic [4:0] d0,
                      input logic [4:0] t1, input logic [4:0] d1);
    rst                 = r;
    enable              = en;
    temperature         = {t1, t0};
    desired_temperature = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] h, input logic [1:0] c,
                       input logic [1:0] f, input logic a);
    n_checks++;
    if ({heating, cooling, fault, any_active} !== {h, c, f, a}) begin
      n_fail++;
      $display("FAIL %s: got heat=%b cool=%b fault=%b any=%b, expected heat=%b cool=%b fault=%b any=%b",
               name, heating, cooling, fault, any_active, h, c, f, a);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 2'b00; temperature = '0; desired_temperature = '0;

    //             rst en     t0  d0  t1  d1  heat   cool   flt    any
    vecs.push_back('{1, 2'b01,  5, 22,  0,  0, 2'b00, 2'b00, 2'b00, 0}); // reset
    vecs.push_back('{0, 2'b01,  5, 22,  0,  0, 2'b01, 2'b00, 2'b00, 1}); // release
    vecs.push_back('{0, 2'b00,  5, 22,  0,  0, 2'b00, 2'b00, 2'b00, 0}); // disable
    vecs.push_back('{0, 2'b01, 19, 20,  0,  0, 2'b00, 2'b00, 2'b00, 0}); // in band
    vecs.push_back('{0, 2'b01, 18, 20,  0,  0, 2'b01, 2'b00, 2'b00, 1}); // T=LO
    vecs.push_back('{0, 2'b01, 19, 20,  0,  0, 2'b01, 2'b00, 2'b00, 1});
    vecs.push_back('{0, 2'b01, 20, 20,  0,  0, 2'b00, 2'b00, 2'b00, 0}); // T=D exit
    vecs.push_back('{0, 2'b01, 22, 20,  0,  0, 2'b00, 2'b01, 2'b00, 1}); // T=HI
    vecs.push_back('{0, 2'b01, 21, 20,  0,  0, 2'b00, 2'b01, 2'b00, 1});
    vecs.push_back('{0, 2'b01, 20, 20,  0,  0, 2'b00, 2'b00, 2'b00, 0});
    vecs.push_back('{0, 2'b01, 30, 31,  0,  0, 2'b00, 2'b00, 2'b00, 0}); // HI saturates
    vecs.push_back('{0, 2'b01,  1,  1,  0,  0, 2'b00, 2'b00, 2'b00, 0}); // LO saturates
    vecs.push_back('{0, 2'b01,  0,  1,  0,  0, 2'b01, 2'b00, 2'b00, 1});
    vecs.push_back('{0, 2'b01,  1,  1,  0,  0, 2'b00, 2'b00, 2'b00, 0});
    vecs.push_back('{0, 2'b11,  5, 22, 30, 20, 2'b01, 2'b10, 2'b00, 1}); // both zones
    vecs.push_back('{0, 2'b11,  5, 22, 30, 20, 2'b01, 2'b10, 2'b00, 1});
    vecs.push_back('{1, 2'b11,  5, 22, 30, 20, 2'b00, 2'b00, 2'b00, 0}); // rst mid-run
    vecs.push_back('{0, 2'b10,  5, 22, 30, 20, 2'b00, 2'b10, 2'b00, 1}); // zone 1 only
    vecs.push_back('{0, 2'b00,  5, 22, 30, 20, 2'b00, 2'b00, 2'b00, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].en, vecs[i].t0, vecs[i].d0, vecs[i].t1, vecs[i].d1);
      check($sformatf("vec%0d", i), vecs[i].heat, vecs[i].cool, vecs[i].flt, vecs[i].any);
    end

    // Timeout: 64 heating cycles, then sticky fault.
    step(0, 2'b01, 5, 22, 0, 0);
    check("fault_heat_start", 2'b01, 2'b00, 2'b00, 1'b1);
    for (int k = 1; k < 64; k++) begin
      step(0, 2'b01, 5, 22, 0, 0);
      check($sformatf("fault_heat_%0d", k), 2'b01, 2'b00, 2'b00, 1'b1);
    end
    step(0, 2'b01, 5, 22, 0, 0);
    check("fault_raise", 2'b00, 2'b00, 2'b01, 1'b0);
    step(0, 2'b01, 22, 22, 0, 0);
    check("fault_sticky_a", 2'b00, 2'b00, 2'b01, 1'b0);
    step(0, 2'b01, 22, 22, 0, 0);
    check("fault_sticky_b", 2'b00, 2'b00, 2'b01, 1'b0);
    step(0, 2'b00, 22, 22, 0, 0);
    check("fault_clear", 2'b00, 2'b00, 2'b00, 1'b0);
    step(0, 2'b01, 22, 22, 0, 0);
    check("reenable_idle", 2'b00, 2'b00, 2'b00, 1'b0);

    // Fault maturing on the same edge as the T>=D exit wins.
    step(0, 2'b01, 5, 22, 0, 0);
    check("race_start", 2'b01, 2'b00, 2'b00, 1'b1);
    for (int k = 1; k < 64; k++) step(0, 2'b01, 5, 22, 0, 0);
    check("race_heat_63", 2'b01, 2'b00, 2'b00, 1'b1);
    step(0, 2'b01, 22, 22, 0, 0);
    check("race_fault_wins", 2'b00, 2'b00, 2'b01, 1'b0);
    step(1, 2'b01, 22, 22, 0, 0);
    check("rst_in_fault", 2'b00, 2'b00, 2'b00, 1'b0);

    // Cooling timeout on zone 1 while zone 0 idles.
    step(0, 2'b10, 0, 0, 30, 20);
    check("cool_fault_start", 2'b00, 2'b10, 2'b00, 1'b1);
    for (int k = 1; k < 64; k++) step(0, 2'b10, 0, 0, 30, 20);
    check("cool_fault_63", 2'b00, 2'b10, 2'b00, 1'b1);
    step(0, 2'b10, 0, 0, 30, 20);
    check("cool_fault_raise", 2'b00, 2'b00, 2'b10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
